// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB register bank: bus widths, the
// acknowledge FSM state type, byte-lane merge and window word index.
package opb_reg_pkg;

  localparam int OPB_AW = 32;
  localparam int OPB_DW = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_t;

  // OPB numbers byte enables MSB-first: be[0] gates data bits 31:24.
  function automatic logic [OPB_DW-1:0] be_merge(
    input logic [OPB_DW-1:0] old_word,
    input logic [OPB_DW-1:0] wdata,
    input logic [0:3]        be
  );
    logic [OPB_DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[3-b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

  function automatic logic [OPB_AW-1:0] addr_index(
    input logic [OPB_AW-1:0] abus,
    input logic [OPB_AW-1:0] base
  );
    logic [OPB_AW-1:0] offset;
    offset = abus - base;
    return {2'b00, offset[OPB_AW-1:2]};
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave front end: window hit decode, IDLE/ACK handshake FSM and
// the xferAck/errAck outputs; hands the decoded request to the register array.
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [OPB_AW-1:0] C_BASEADDR = 32'h01080300,
  parameter logic [OPB_AW-1:0] C_HIGHADDR = 32'h010803FF,
  parameter int                NUM_REGS   = 8,
  parameter int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPB_AW-1:0] abus,
  input  logic [0:3]        be,
  input  logic [OPB_DW-1:0] dbus,
  input  logic              rnw,
  input  logic              select,
  output logic              xfer_ack,
  output logic              err_ack,
  output logic              req_wr,
  output logic              req_rd,
  output logic [IDX_W-1:0]  req_idx,
  output logic [OPB_DW-1:0] req_wdata,
  output logic [0:3]        req_be
);

  ack_state_t        state_r;
  logic              xfer_ack_r;
  logic              err_ack_r;
  logic [OPB_AW-1:0] offset_s;
  logic              hit_s;
  logic              idx_ok_s;
  logic              commit_s;

  // Address decode; requests only commit while the FSM is idle.
  always_comb begin
    offset_s = addr_index(abus, C_BASEADDR);
    hit_s    = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    idx_ok_s = (offset_s < OPB_AW'(NUM_REGS));
    commit_s = (state_r == IDLE) && hit_s && idx_ok_s;
  end

  // Handshake FSM: one ack cycle per hit, then back to IDLE unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      xfer_ack_r <= 1'b0;
      err_ack_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            state_r    <= ACK;
            xfer_ack_r <= 1'b1;
            err_ack_r  <= ~idx_ok_s;
          end else begin
            state_r    <= IDLE;
            xfer_ack_r <= 1'b0;
            err_ack_r  <= 1'b0;
          end
        end
        ACK: begin
          state_r    <= IDLE;
          xfer_ack_r <= 1'b0;
          err_ack_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          xfer_ack_r <= 1'b0;
          err_ack_r  <= 1'b0;
        end
      endcase
    end
  end

  assign xfer_ack  = xfer_ack_r;
  assign err_ack   = err_ack_r;
  assign req_wr    = commit_s & ~rnw;
  assign req_rd    = commit_s & rnw;
  assign req_idx   = offset_s[IDX_W-1:0];
  assign req_wdata = dbus;
  assign req_be    = be;

endmodule

// File: rtl/opb_register_bank.sv
// Bank of NUM_REGS 32-bit software registers behind one OPB slave window;
// each register is either PPC-written (with byte enables) or fabric-sampled.
module opb_register_bank
  import opb_reg_pkg::*;
#(
  parameter logic [OPB_AW-1:0]      C_BASEADDR = 32'h01080300,
  parameter logic [OPB_AW-1:0]      C_HIGHADDR = 32'h010803FF,
  parameter int                     NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]    RD_MASK    = {NUM_REGS{1'b0}},
  parameter logic [NUM_REGS*32-1:0] INIT_VAL   = {NUM_REGS{32'h0000_0000}}
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst_n,
  input  logic [0:31]            OPB_ABus,
  input  logic [0:3]             OPB_BE,
  input  logic [0:31]            OPB_DBus,
  input  logic                   OPB_RNW,
  input  logic                   OPB_select,
  input  logic                   OPB_seqAddr,
  output logic [0:31]            Sl_DBus,
  output logic                   Sl_xferAck,
  output logic                   Sl_errAck,
  output logic                   Sl_retry,
  output logic                   Sl_toutSup,
  output logic [NUM_REGS*32-1:0] user_data_out,
  input  logic [NUM_REGS*32-1:0] user_data_in,
  output logic [NUM_REGS-1:0]    user_wr_stb,
  output logic [NUM_REGS-1:0]    user_rd_stb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              req_wr_s;
  logic              req_rd_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [OPB_DW-1:0] req_wdata_s;
  logic [0:3]        req_be_s;
  logic [OPB_DW-1:0] rd_word_s;
  logic [OPB_DW-1:0] regs_r   [NUM_REGS];
  logic [OPB_DW-1:0] shadow_r [NUM_REGS];
  logic [OPB_DW-1:0] sl_dbus_r;
  logic [NUM_REGS-1:0] wr_stb_r;
  logic [NUM_REGS-1:0] rd_stb_r;
  logic              unused_seq_addr;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_ack_fsm (
    .clk       (OPB_Clk),
    .rst_n     (OPB_Rst_n),
    .abus      (OPB_ABus),
    .be        (OPB_BE),
    .dbus      (OPB_DBus),
    .rnw       (OPB_RNW),
    .select    (OPB_select),
    .xfer_ack  (Sl_xferAck),
    .err_ack   (Sl_errAck),
    .req_wr    (req_wr_s),
    .req_rd    (req_rd_s),
    .req_idx   (req_idx_s),
    .req_wdata (req_wdata_s),
    .req_be    (req_be_s)
  );

  // Write registers: byte-merged update on a committed write; read slots stay 0.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RD_MASK[i] ? 32'h0000_0000 : INIT_VAL[32*i +: 32];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (req_wr_s && (req_idx_s == IDX_W'(i)) && !RD_MASK[i]) begin
          regs_r[i] <= be_merge(regs_r[i], req_wdata_s, req_be_s);
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read shadows sample the fabric inputs every cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= user_data_in[32*i +: 32];
      end
    end
  end

  // Read-data source for the addressed register.
  always_comb begin
    if (RD_MASK[req_idx_s]) begin
      rd_word_s = shadow_r[req_idx_s];
    end else begin
      rd_word_s = regs_r[req_idx_s];
    end
  end

  // Registered bus read data and per-register strobes; all zero outside the ack cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      sl_dbus_r <= 32'h0000_0000;
      wr_stb_r  <= {NUM_REGS{1'b0}};
      rd_stb_r  <= {NUM_REGS{1'b0}};
    end else begin
      if (req_rd_s) begin
        sl_dbus_r <= rd_word_s;
      end else begin
        sl_dbus_r <= 32'h0000_0000;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_stb_r[i] <= req_wr_s && (req_idx_s == IDX_W'(i)) && !RD_MASK[i];
        rd_stb_r[i] <= req_rd_s && (req_idx_s == IDX_W'(i));
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = RD_MASK[g] ? 32'h0000_0000 : regs_r[g];
  end

  assign Sl_DBus         = sl_dbus_r;
  assign user_wr_stb     = wr_stb_r;
  assign user_rd_stb     = rd_stb_r;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign unused_seq_addr = OPB_seqAddr;

endmodule
